palette_lut: RTL and testbench

- Programmable, parametrised successor to the fixed 16-colour palette decoder; maps a pixel colour code to RGB through a writable lookup table.
- Adds a 2-stage registered lookup pipeline with valid tracking, global brightness scaling, and a timed fade-in/fade-out state machine.
- A transparency flag marks the key colour code.
- Sits between the sprite/background colour-code mux and the VGA output registers.

---
 rtl/palette_pkg.sv | 44 ++++
 rtl/palette_fader.sv | 100 ++++++++++
 rtl/palette_lut.sv | 128 ++++++++++++
 tb/tb_palette_lut.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// palette_pkg
// Shared types and constants for the programmable palette lookup.
//   fade_state_t    : states of the brightness fade machine
//   rgb_t           : one 8-bit-per-channel palette colour
//   DEFAULT_PALETTE : the 16 colours the table holds after reset
//   BRIGHT_MAX      : full brightness (colours pass through unscaled)
package palette_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        FADE_OUT = 2'd2
    } fade_state_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    localparam logic [7:0] BRIGHT_MAX = 8'd255;

    // Entries 14 and 15 are intentionally the same brown; this matches the
    // fixed decoder this table replaces.
    localparam rgb_t DEFAULT_PALETTE [16] = '{
        '{8'hFF, 8'h00, 8'hFF},
        '{8'h00, 8'h00, 8'h00},
        '{8'hFF, 8'hFF, 8'hFF},
        '{8'hFF, 8'hC9, 8'h0E},
        '{8'h26, 8'h34, 8'hD9},
        '{8'hED, 8'h1C, 8'h24},
        '{8'h80, 8'h00, 8'hFF},
        '{8'hFF, 8'h7F, 8'h27},
        '{8'h88, 8'h00, 8'h15},
        '{8'hE6, 8'hCE, 8'hC1},
        '{8'h00, 8'hA2, 8'hE8},
        '{8'h00, 8'h80, 8'h00},
        '{8'h5E, 8'h00, 8'h0E},
        '{8'h22, 8'hB1, 8'h4C},
        '{8'h7E, 8'h4F, 8'h34},
        '{8'h7E, 8'h4F, 8'h34}
    };

endpackage

// File: rtl/palette_fader.sv
// palette_fader
// Global brightness register with a timed fade-in / fade-out machine.
//   clk, reset                 : clock, synchronous active-high reset
//   bright_set_en/_val         : direct brightness load (highest priority)
//   fade_in_start              : ramp brightness up to BRIGHT_MAX
//   fade_out_start             : ramp brightness down to 0
//   brightness                 : current brightness
//   fade_busy                  : machine is mid-fade
//   fade_done                  : one-cycle pulse when a fade hits its limit
module palette_fader
    import palette_pkg::*;
#(
    parameter int FADE_DIV  = 65536,
    parameter int FADE_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bright_set_en,
    input  logic [7:0] bright_set_val,
    input  logic       fade_in_start,
    input  logic       fade_out_start,
    output logic [7:0] brightness,
    output logic       fade_busy,
    output logic       fade_done
);

    localparam int               DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [7:0]       STEP_B   = 8'(FADE_STEP);

    fade_state_t      state;
    logic [DIV_W-1:0] divider;
    logic             upSat;
    logic             downSat;

    // Saturation tests are done in int so a step larger than the headroom
    // never wraps the 8-bit brightness.
    assign upSat     = (int'(brightness) + FADE_STEP) >= int'(BRIGHT_MAX);
    assign downSat   = int'(brightness) <= FADE_STEP;
    assign fade_busy = (state != IDLE);

    // Single fade machine. Priority: direct load, then fade-in start, then
    // fade-out start, then normal stepping. A start that finds brightness
    // already at its target completes immediately with a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            brightness <= BRIGHT_MAX;
            divider    <= '0;
            fade_done  <= 1'b0;
        end else begin
            fade_done <= 1'b0;
            if (bright_set_en) begin
                brightness <= bright_set_val;
                state      <= IDLE;
                divider    <= '0;
            end else if (fade_in_start) begin
                divider <= '0;
                if (brightness == BRIGHT_MAX) begin
                    state     <= IDLE;
                    fade_done <= 1'b1;
                end else begin
                    state <= FADE_IN;
                end
            end else if (fade_out_start) begin
                divider <= '0;
                if (brightness == 8'd0) begin
                    state     <= IDLE;
                    fade_done <= 1'b1;
                end else begin
                    state <= FADE_OUT;
                end
            end else if (state != IDLE) begin
                if (divider == DIV_LAST) begin
                    divider <= '0;
                    if (state == FADE_IN) begin
                        if (upSat) begin
                            brightness <= BRIGHT_MAX;
                            state      <= IDLE;
                            fade_done  <= 1'b1;
                        end else begin
                            brightness <= brightness + STEP_B;
                        end
                    end else begin
                        if (downSat) begin
                            brightness <= 8'd0;
                            state      <= IDLE;
                            fade_done  <= 1'b1;
                        end else begin
                            brightness <= brightness - STEP_B;
                        end
                    end
                end else begin
                    divider <= divider + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/palette_lut.sv
// palette_lut
// Writable colour-code to RGB lookup with a 2-stage pipeline, global
// brightness scaling and a transparency flag for the key colour.
//   clk, reset                  : clock, synchronous active-high reset
//   pix_valid_in, pix_code      : pixel code to look up
//   wr_en, wr_addr, wr_red/green/blue : table write port
//   bright_set_en/_val, fade_in_start, fade_out_start : brightness control
//   pix_valid_out, red/green/blue, transparent : result, 2 cycles later
//   brightness, fade_busy, fade_done : fade machine status
module palette_lut
    import palette_pkg::*;
#(
    parameter int CODE_W    = 4,
    parameter int COLOR_W   = 8,
    parameter int FADE_DIV  = 65536,
    parameter int FADE_STEP = 4,
    parameter int KEY_CODE  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid_in,
    input  logic [CODE_W-1:0]  pix_code,
    input  logic               wr_en,
    input  logic [CODE_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_red,
    input  logic [COLOR_W-1:0] wr_green,
    input  logic [COLOR_W-1:0] wr_blue,
    input  logic               bright_set_en,
    input  logic [7:0]         bright_set_val,
    input  logic               fade_in_start,
    input  logic               fade_out_start,
    output logic               pix_valid_out,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               transparent,
    output logic [7:0]         brightness,
    output logic               fade_busy,
    output logic               fade_done
);

    localparam int DEPTH = 2 ** CODE_W;
    localparam int PW    = COLOR_W + 9;

    logic [COLOR_W-1:0] tabRed   [DEPTH];
    logic [COLOR_W-1:0] tabGreen [DEPTH];
    logic [COLOR_W-1:0] tabBlue  [DEPTH];

    logic               s1Valid;
    logic [COLOR_W-1:0] s1Red;
    logic [COLOR_W-1:0] s1Green;
    logic [COLOR_W-1:0] s1Blue;
    logic               s1Transp;

    // (c * (b+1)) >> 8: brightness 255 is an exact pass-through, 0 is black.
    function automatic logic [COLOR_W-1:0] scaleChan(input logic [COLOR_W-1:0] c,
                                                     input logic [7:0] b);
        logic [PW-1:0] prod;
        prod = PW'(c) * PW'({1'b0, b} + 9'd1);
        return prod[COLOR_W+7:8];
    endfunction

    palette_fader #(
        .FADE_DIV  (FADE_DIV),
        .FADE_STEP (FADE_STEP)
    ) u_fader (
        .clk            (clk),
        .reset          (reset),
        .bright_set_en  (bright_set_en),
        .bright_set_val (bright_set_val),
        .fade_in_start  (fade_in_start),
        .fade_out_start (fade_out_start),
        .brightness     (brightness),
        .fade_busy      (fade_busy),
        .fade_done      (fade_done)
    );

    // Palette table. Reset reloads the default colours (entries beyond the
    // first 16 become black) and overrides any write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tabRed[i]   <= (i < 16) ? COLOR_W'(DEFAULT_PALETTE[i % 16].red)   : '0;
                tabGreen[i] <= (i < 16) ? COLOR_W'(DEFAULT_PALETTE[i % 16].green) : '0;
                tabBlue[i]  <= (i < 16) ? COLOR_W'(DEFAULT_PALETTE[i % 16].blue)  : '0;
            end
        end else if (wr_en) begin
            tabRed[wr_addr]   <= wr_red;
            tabGreen[wr_addr] <= wr_green;
            tabBlue[wr_addr]  <= wr_blue;
        end
    end

    // Lookup pipeline. Stage 1 reads the table before any same-cycle write
    // lands, so a simultaneous write/lookup returns the old colour. Stage 2
    // scales with whatever brightness is current as the pixel passes through.
    // Data registers only move with their valid, so they hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid       <= 1'b0;
            s1Red         <= '0;
            s1Green       <= '0;
            s1Blue        <= '0;
            s1Transp      <= 1'b0;
            pix_valid_out <= 1'b0;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
            transparent   <= 1'b0;
        end else begin
            s1Valid       <= pix_valid_in;
            pix_valid_out <= s1Valid;
            if (pix_valid_in) begin
                s1Red    <= tabRed[pix_code];
                s1Green  <= tabGreen[pix_code];
                s1Blue   <= tabBlue[pix_code];
                s1Transp <= (pix_code == CODE_W'(KEY_CODE));
            end
            if (s1Valid) begin
                red         <= scaleChan(s1Red, brightness);
                green       <= scaleChan(s1Green, brightness);
                blue        <= scaleChan(s1Blue, brightness);
                transparent <= s1Transp;
            end
        end
    end

endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut
// Self-checking bench for palette_lut. Pixel expectations are pushed to a
// scoreboard queue as codes are driven and popped when pix_valid_out fires.
module tb_palette_lut;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_valid_in = 1'b0;
    logic [3:0] pix_code = '0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_red = '0;
    logic [7:0] wr_green = '0;
    logic [7:0] wr_blue = '0;
    logic       bright_set_en = 1'b0;
    logic [7:0] bright_set_val = '0;
    logic       fade_in_start = 1'b0;
    logic       fade_out_start = 1'b0;
    logic       pix_valid_out;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       transparent;
    logic [7:0] brightness;
    logic       fade_busy;
    logic       fade_done;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       t;
    } exp_t;

    exp_t        sbq[$];
    logic [23:0] model[16];
    int          brightModel;
    int          checks = 0;
    int          passed = 0;

    palette_lut #(
        .CODE_W    (4),
        .COLOR_W   (8),
        .FADE_DIV  (2),
        .FADE_STEP (64),
        .KEY_CODE  (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pix_valid_in   (pix_valid_in),
        .pix_code       (pix_code),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_red         (wr_red),
        .wr_green       (wr_green),
        .wr_blue        (wr_blue),
        .bright_set_en  (bright_set_en),
        .bright_set_val (bright_set_val),
        .fade_in_start  (fade_in_start),
        .fade_out_start (fade_out_start),
        .pix_valid_out  (pix_valid_out),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .transparent    (transparent),
        .brightness     (brightness),
        .fade_busy      (fade_busy),
        .fade_done      (fade_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] scaleRef(input logic [7:0] c, input int b);
        int p;
        p = int'(c) * (b + 1);
        return 8'(p / 256);
    endfunction

    function automatic exp_t expectFor(input int code);
        logic [23:0] e;
        e = model[code];
        return {scaleRef(e[23:16], brightModel), scaleRef(e[15:8], brightModel),
                scaleRef(e[7:0], brightModel), (code == 0)};
    endfunction

    task automatic loadModel;
        model[0]  = 24'hFF00FF; model[1]  = 24'h000000;
        model[2]  = 24'hFFFFFF; model[3]  = 24'hFFC90E;
        model[4]  = 24'h2634D9; model[5]  = 24'hED1C24;
        model[6]  = 24'h8000FF; model[7]  = 24'hFF7F27;
        model[8]  = 24'h880015; model[9]  = 24'hE6CEC1;
        model[10] = 24'h00A2E8; model[11] = 24'h008000;
        model[12] = 24'h5E000E; model[13] = 24'h22B14C;
        model[14] = 24'h7E4F34; model[15] = 24'h7E4F34;
        brightModel = 255;
    endtask

    task automatic applyStimulusReset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        loadModel();
        sbq.delete();
    endtask

    task automatic applyStimulusBright(input int v);
        @(negedge clk);
        bright_set_en  = 1'b1;
        bright_set_val = 8'(v);
        @(negedge clk);
        bright_set_en = 1'b0;
        brightModel   = v;
    endtask

    task automatic test_reset;
        // Hold reset with a competing write to entry 3; reset must win.
        reset    = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 4'd3;
        wr_red   = 8'h00;
        wr_green = 8'h00;
        wr_blue  = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({pix_valid_out, red, green, blue, transparent} !== 26'd0)
            $display("[TB] FAIL reset_outputs got=%h want=0",
                     {pix_valid_out, red, green, blue, transparent});
        else passed++;
        checks++;
        if (brightness !== 8'd255) $display("[TB] FAIL reset_bright got=%0d want=255", brightness);
        else passed++;
        checks++;
        if ({fade_busy, fade_done} !== 2'b00)
            $display("[TB] FAIL reset_fade got=%b want=00", {fade_busy, fade_done});
        else passed++;
        reset = 1'b0;
        wr_en = 1'b0;
        loadModel();
    endtask

    task automatic test_lookup;
        int   codes[3] = '{3, 5, 0};
        int   firstK = -1;
        int   lastK = -1;
        int   nOut = 0;
        exp_t got;
        exp_t want;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (pix_valid_out) begin
                got = {red, green, blue, transparent};
                if (firstK < 0) firstK = k;
                lastK = k;
                nOut++;
                checks++;
                if (sbq.size() == 0) $display("[TB] FAIL lookup_extra got=%h want=none", got);
                else begin
                    want = sbq.pop_front();
                    if (got !== want) $display("[TB] FAIL lookup_pixel got=%h want=%h", got, want);
                    else passed++;
                end
            end
            if (k < 3) begin
                pix_valid_in = 1'b1;
                pix_code     = 4'(codes[k]);
                sbq.push_back(expectFor(codes[k]));
            end else begin
                pix_valid_in = 1'b0;
            end
        end
        checks++;
        if (firstK !== 2 || nOut !== 3 || (lastK - firstK + 1) !== 3)
            $display("[TB] FAIL lookup_valid_pulse got=first%0d/n%0d/span%0d want=first2/n3/span3",
                     firstK, nOut, lastK - firstK + 1);
        else passed++;
        checks++;
        if (sbq.size() !== 0) $display("[TB] FAIL lookup_missing got=%0d want=0", sbq.size());
        else passed++;
    endtask

    task automatic test_write_bypass;
        exp_t got;
        exp_t want;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pix_valid_out) begin
                got = {red, green, blue, transparent};
                checks++;
                if (sbq.size() == 0) $display("[TB] FAIL write_extra got=%h want=none", got);
                else begin
                    want = sbq.pop_front();
                    if (got !== want) $display("[TB] FAIL write_pixel got=%h want=%h", got, want);
                    else passed++;
                end
            end
            wr_en        = 1'b0;
            pix_valid_in = 1'b0;
            if (k < 2) begin
                pix_valid_in = 1'b1;
                pix_code     = 4'd2;
                sbq.push_back(expectFor(2));
            end
            if (k == 0) begin
                wr_en    = 1'b1;
                wr_addr  = 4'd2;
                wr_red   = 8'h12;
                wr_green = 8'h34;
                wr_blue  = 8'h56;
                model[2] = 24'h123456;
            end
        end
        checks++;
        if (sbq.size() !== 0) $display("[TB] FAIL write_missing got=%0d want=0", sbq.size());
        else passed++;
    endtask

    task automatic test_brightness;
        int   levels[2] = '{127, 0};
        int   codes[2][2] = '{'{2, 0}, '{0, 2}};
        exp_t got;
        exp_t want;
        applyStimulusReset();
        for (int ph = 0; ph < 2; ph++) begin
            applyStimulusBright(levels[ph]);
            checks++;
            if (brightness !== 8'(levels[ph]))
                $display("[TB] FAIL bright_load got=%0d want=%0d", brightness, levels[ph]);
            else passed++;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (pix_valid_out) begin
                    got = {red, green, blue, transparent};
                    checks++;
                    if (sbq.size() == 0) $display("[TB] FAIL bright_extra got=%h want=none", got);
                    else begin
                        want = sbq.pop_front();
                        if (got !== want) $display("[TB] FAIL bright_pixel got=%h want=%h", got, want);
                        else passed++;
                    end
                end
                if (k < 2) begin
                    pix_valid_in = 1'b1;
                    pix_code     = 4'(codes[ph][k]);
                    sbq.push_back(expectFor(codes[ph][k]));
                end else begin
                    pix_valid_in = 1'b0;
                end
            end
        end
        checks++;
        if (sbq.size() !== 0) $display("[TB] FAIL bright_missing got=%0d want=0", sbq.size());
        else passed++;
    endtask

    task automatic test_fade_out;
        int expSeq[4] = '{191, 127, 63, 0};
        int idx = 0;
        int lastK = 0;
        int doneCnt = 0;
        int doneBright = -1;
        int prev = 255;
        applyStimulusReset();
        @(negedge clk);
        fade_out_start = 1'b1;
        @(negedge clk);
        fade_out_start = 1'b0;
        checks++;
        if (fade_busy !== 1'b1) $display("[TB] FAIL fadeout_busy got=%b want=1", fade_busy);
        else passed++;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (fade_done) begin
                doneCnt++;
                doneBright = int'(brightness);
            end
            if (int'(brightness) != prev) begin
                checks++;
                if (idx >= 4) $display("[TB] FAIL fadeout_extra got=%0d want=none", brightness);
                else if (int'(brightness) !== expSeq[idx] || (idx > 0 && (k - lastK) !== 2))
                    $display("[TB] FAIL fadeout_step got=%0d@+%0d want=%0d@+2",
                             brightness, k - lastK, expSeq[idx]);
                else passed++;
                idx++;
                lastK = k;
                prev  = int'(brightness);
            end
        end
        checks++;
        if (idx !== 4 || doneCnt !== 1 || doneBright !== 0)
            $display("[TB] FAIL fadeout_done got=steps%0d/done%0d/at%0d want=steps4/done1/at0",
                     idx, doneCnt, doneBright);
        else passed++;
        checks++;
        if (fade_busy !== 1'b0) $display("[TB] FAIL fadeout_idle got=%b want=0", fade_busy);
        else passed++;
    endtask

    task automatic test_fade_reverse;
        int  prev;
        logic seen;
        applyStimulusReset();
        applyStimulusBright(100);
        @(negedge clk);
        fade_in_start  = 1'b1;
        fade_out_start = 1'b1;
        @(negedge clk);
        fade_in_start  = 1'b0;
        fade_out_start = 1'b0;
        prev = int'(brightness);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (int'(brightness) != prev) seen = 1'b1;
        end
        checks++;
        if (!seen || brightness !== 8'd164)
            $display("[TB] FAIL reverse_up got=%0d seen%b want=164", brightness, seen);
        else passed++;
        fade_out_start = 1'b1;
        @(negedge clk);
        fade_out_start = 1'b0;
        prev = int'(brightness);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (int'(brightness) != prev) seen = 1'b1;
        end
        checks++;
        if (!seen || brightness !== 8'd100 || fade_busy !== 1'b1)
            $display("[TB] FAIL reverse_down got=%0d busy%b want=100 busy1", brightness, fade_busy);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({brightness, fade_busy, fade_done} !== {8'd255, 2'b00})
            $display("[TB] FAIL reverse_reset got=%0d/%b/%b want=255/0/0",
                     brightness, fade_busy, fade_done);
        else passed++;
        repeat (6) @(negedge clk);
        checks++;
        if (brightness !== 8'd255 || fade_busy !== 1'b0)
            $display("[TB] FAIL reverse_settled got=%0d/%b want=255/0", brightness, fade_busy);
        else passed++;
        loadModel();
    endtask

    task automatic test_fade_at_target;
        applyStimulusReset();
        @(negedge clk);
        fade_in_start = 1'b1;
        @(negedge clk);
        fade_in_start = 1'b0;
        checks++;
        if (fade_done !== 1'b1 || brightness !== 8'd255)
            $display("[TB] FAIL target_done got=%b/%0d want=1/255", fade_done, brightness);
        else passed++;
        @(negedge clk);
        checks++;
        if ({fade_done, fade_busy} !== 2'b00 || brightness !== 8'd255)
            $display("[TB] FAIL target_after got=%b%b/%0d want=00/255",
                     fade_done, fade_busy, brightness);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_write_bypass();
        test_brightness();
        test_fade_out();
        test_fade_reverse();
        test_fade_at_target();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
